cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Control unit driving the 16-bit datapath: register file, ALU, write-back mux and data memory.
- Fetches 16-bit instructions from an asynchronous-read instruction ROM and decodes them in a multi-cycle Moore FSM.
- Emits per-cycle datapath controls: D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0.
- Together with the datapath this forms the complete CPU core.

Parameters:
PC_W, 7, instruction-memory address width (program counter width)
IW, 16, instruction width
DAW, 8, data-memory address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
IM_addr  output  PC_W  instruction ROM address (equals PC)
IM_rd  output  1  instruction read strobe, high in FETCH only
IM_data  input  IW  instruction word, combinationally valid for the current IM_addr
D_Addr  output  DAW  data-memory address
D_wr  output  1  data-memory write enable
RF_s  output  1  write-back mux select: 0 = ALU, 1 = data memory
RF_W_addr  output  4  register-file write address
RF_W_en  output  1  register-file write enable
RF_Ra_addr  output  4  register-file read port A address
RF_Rb_addr  output  4  register-file read port B address
Alu_s0  output  4  ALU operation select
halted  output  1  high while in HALT
state_o  output  4  current state encoding, for debug

Behaviour:
- Internal registers: PC (PC_W bits), IR (IW bits), state.
- All outputs are a combinational function of state and IR only (Moore). No output depends on IM_data.
- Every output not explicitly driven in a state is 0.
- Reset (asynchronous): state=INIT, PC=0, IR=0, all outputs 0 immediately. Reset mid-instruction abandons it with no partial write.
- Opcode = IR[15:12]:
  - NOOP 0x0
  - STORE 0x1: D[IR[11:4]] <= R[IR[3:0]]
  - LOAD 0x2: R[IR[3:0]] <= D[IR[11:4]]
  - ADD 0x3: R[IR[3:0]] <= R[IR[11:8]] + R[IR[7:4]]
  - SUB 0x4: R[IR[3:0]] <= R[IR[11:8]] - R[IR[7:4]]
  - HALT 0x5
  - 0x6-0xF: executed as NOOP
- INIT: -> FETCH, one cycle.
- FETCH: IM_addr=PC, IM_rd=1. On the edge: IR<=IM_data, PC<=PC+1 (wraps 2^PC_W-1 -> 0). -> DECODE.
- DECODE: no controls. -> state by opcode; NOOP/undefined -> FETCH.
- STORE: D_Addr=IR[11:4], RF_Ra_addr=IR[3:0], D_wr=1. -> FETCH.
- LOAD_A: D_Addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=0. Lets the synchronous-read data memory produce data. -> LOAD_B.
- LOAD_B: same as LOAD_A but RF_W_en=1. -> FETCH.
- ADD/SUB:
  - RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_s=0, RF_W_en=1.
  - Alu_s0=ALU_ADD (4'd1) or ALU_SUB (4'd2).
  - -> FETCH.
- HALT: halted=1. Absorbing state; PC and IR frozen; exit only by reset.
- Cycle counts including FETCH and DECODE: NOOP 2, STORE 3, ADD/SUB 3, LOAD 4.
- D_wr and RF_W_en are never both 1 in the same cycle.
- Alu_s0 is ALU_PASS (4'd0) outside ADD/SUB.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants OP_NOOP..OP_HALT
  - ALU select constants ALU_PASS, ALU_ADD, ALU_SUB
  - state enum typedef: INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT
- One sub-module: pc_reg (async-reset PC with load-zero and increment). FSM and output decode stay in cpu_controller.
- A wrapper cpu_top instantiates cpu_controller, the datapath and the instruction ROM.

Test Plan:
- Reset held 3 cycles, then released: all outputs 0 during reset; INIT for 1 cycle then FETCH with IM_addr=0, IM_rd=1.
- Program 0x2051 (LOAD R1,D[5]): LOAD_A shows D_Addr=5, RF_s=1, RF_W_addr=1, RF_W_en=0. Next cycle RF_W_en=1. Next FETCH at IM_addr=1.
- Program 0x3123 (ADD): RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=3, Alu_s0=1, RF_s=0, RF_W_en=1 for exactly one cycle. 0x4123 is the same with Alu_s0=2.
- Full program 2051, 2062, 3123, 1073, 5000 with D[5]=3, D[6]=4 in a cpu_top bench:
  - D[7]=7 after the STORE (D_Addr=7, D_wr=1, RF_Ra_addr=3).
  - halted=1 at cycle 17 after INIT, and stays 1 for 20 further cycles with IM_rd=0.
- Opcode 0xA000 and 0x0000: FETCH -> DECODE -> FETCH with no write enables. PC preloaded to 127 wraps to 0.
- Reset asserted in LOAD_A: outputs zero asynchronously, RF_W_en never pulses. After release, fetch restarts at PC=0.

Source files
------------

// File: rtl/cpu_controller_pkg.sv
// Shared opcode, ALU-select and FSM state definitions for the CPU control unit.
package cpu_pkg;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [3:0] ALU_PASS = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    LOAD_A = 4'd3,
    LOAD_B = 4'd4,
    STORE  = 4'd5,
    ADD    = 4'd6,
    SUB    = 4'd7,
    HALT   = 4'd8
  } state_t;

endpackage

// File: rtl/cpu_controller_if.sv
// Instruction-fetch and datapath control bundle between the controller and the core.
interface cpu_controller_if #(
  parameter int PC_W = 7,
  parameter int IW   = 16,
  parameter int DAW  = 8
);
  logic [PC_W-1:0] IM_addr;
  logic            IM_rd;
  logic [IW-1:0]   IM_data;
  logic [DAW-1:0]  D_Addr;
  logic            D_wr;
  logic            RF_s;
  logic [3:0]      RF_W_addr;
  logic            RF_W_en;
  logic [3:0]      RF_Ra_addr;
  logic [3:0]      RF_Rb_addr;
  logic [3:0]      Alu_s0;
  logic            halted;
  logic [3:0]      state_o;

  modport master (
    output IM_addr, IM_rd, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, Alu_s0, halted, state_o,
    input  IM_data
  );

  modport slave (
    input  IM_addr, IM_rd, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, Alu_s0, halted, state_o,
    output IM_data
  );
endinterface

// File: rtl/cpu_controller_pc_reg.sv
// Program counter with asynchronous reset, synchronous clear and wrapping increment.
module pc_reg #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] pc
);

  // Increment wraps naturally from all-ones back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + W'(1);
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle Moore control unit: fetches from an async ROM and sequences the datapath.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int PC_W = 7,
  parameter int IW   = 16,
  parameter int DAW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  cpu_controller_if.master bus
);

  state_t          state, next_state;
  logic [IW-1:0]   ir;
  logic [PC_W-1:0] pc;
  logic [3:0]      opcode;

  assign opcode = ir[15:12];

  pc_reg #(.W(PC_W)) u_pc (
    .clk   (clk),
    .reset (reset),
    .clr   (state == INIT),
    .inc   (state == FETCH),
    .pc    (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // IR only changes on the FETCH edge, so outputs never see IM_data directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= '0;
    end else if (state == FETCH) begin
      ir <= bus.IM_data;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:    next_state = FETCH;
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_STORE: next_state = STORE;
          OP_LOAD:  next_state = LOAD_A;
          OP_ADD:   next_state = ADD;
          OP_SUB:   next_state = SUB;
          OP_HALT:  next_state = HALT;
          default:  next_state = FETCH;
        endcase
      end
      LOAD_A:  next_state = LOAD_B;
      LOAD_B:  next_state = FETCH;
      STORE:   next_state = FETCH;
      ADD:     next_state = FETCH;
      SUB:     next_state = FETCH;
      HALT:    next_state = HALT;
      default: next_state = INIT;
    endcase
  end

  always_comb begin
    bus.IM_addr    = '0;
    bus.IM_rd      = 1'b0;
    bus.D_Addr     = '0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.Alu_s0     = ALU_PASS;
    bus.halted     = 1'b0;
    bus.state_o    = state;
    case (state)
      FETCH: begin
        bus.IM_addr = pc;
        bus.IM_rd   = 1'b1;
      end
      STORE: begin
        bus.D_Addr     = DAW'(ir[11:4]);
        bus.RF_Ra_addr = ir[3:0];
        bus.D_wr       = 1'b1;
      end
      // LOAD_A gives the synchronous-read data memory a cycle before write-back.
      LOAD_A, LOAD_B: begin
        bus.D_Addr    = DAW'(ir[11:4]);
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = ir[3:0];
        bus.RF_W_en   = (state == LOAD_B);
      end
      ADD, SUB: begin
        bus.RF_Ra_addr = ir[11:8];
        bus.RF_Rb_addr = ir[7:4];
        bus.RF_W_addr  = ir[3:0];
        bus.RF_W_en    = 1'b1;
        bus.Alu_s0     = (state == ADD) ? ALU_ADD : ALU_SUB;
      end
      HALT:    bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller; the bench itself plays ROM, register file, ALU and data memory.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  logic model_init;
  int   checks;
  int   failures;

  logic [15:0] rom  [0:127];
  logic [15:0] regs [0:15];
  logic [15:0] dmem [0:255];
  logic [15:0] dmem_q;
  logic [39:0] all_out;
  logic [35:0] ctrl_out;

  cpu_controller_if #(.PC_W(7), .IW(16), .DAW(8)) bus ();

  cpu_controller #(.PC_W(7), .IW(16), .DAW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.IM_data = rom[bus.IM_addr];
  assign all_out = {bus.IM_addr, bus.IM_rd, bus.D_Addr, bus.D_wr, bus.RF_s,
                    bus.RF_W_addr, bus.RF_W_en, bus.RF_Ra_addr, bus.RF_Rb_addr,
                    bus.Alu_s0, bus.halted, bus.state_o};
  assign ctrl_out = all_out[39:4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: sync-read data memory, register file and ALU.
  always @(posedge clk) begin
    if (model_init) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0;
      for (int i = 0; i < 256; i++) dmem[i] <= 16'h0;
      dmem[5] <= 16'd3;
      dmem[6] <= 16'd4;
      dmem_q  <= 16'h0;
    end else begin
      dmem_q <= dmem[bus.D_Addr];
      if (bus.D_wr) dmem[bus.D_Addr] <= regs[bus.RF_Ra_addr];
      if (bus.RF_W_en) begin
        if (bus.RF_s) regs[bus.RF_W_addr] <= dmem_q;
        else if (bus.Alu_s0 == 4'd1) regs[bus.RF_W_addr] <= regs[bus.RF_Ra_addr] + regs[bus.RF_Rb_addr];
        else if (bus.Alu_s0 == 4'd2) regs[bus.RF_W_addr] <= regs[bus.RF_Ra_addr] - regs[bus.RF_Rb_addr];
        else regs[bus.RF_W_addr] <= regs[bus.RF_Ra_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_init = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    reset = 1'b1;
    model_init = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (all_out !== 40'h0) begin
        failures++;
        $display("[TB] FAIL reset_outputs cycle=%0d got=%h exp=0", c, all_out);
      end
    end
    reset = 1'b0;
    model_init = 1'b0;
    checks++;
    if (bus.state_o !== INIT) begin
      failures++;
      $display("[TB] FAIL reset_init got=%0d exp=%0d", bus.state_o, INIT);
    end
    tick();
    checks++;
    if (bus.state_o !== FETCH || bus.IM_addr !== 7'd0 || bus.IM_rd !== 1'b1) begin
      failures++;
      $display("[TB] FAIL first_fetch state=%0d addr=%0d rd=%b exp state=1 addr=0 rd=1",
               bus.state_o, bus.IM_addr, bus.IM_rd);
    end
  endtask

  task automatic test_load();
    clear_rom();
    rom[0] = 16'h2051;
    do_reset();
    tick();
    tick();
    checks++;
    if (bus.state_o !== DECODE || ctrl_out !== 36'h0) begin
      failures++;
      $display("[TB] FAIL load_decode state=%0d ctrl=%h exp state=2 ctrl=0", bus.state_o, ctrl_out);
    end
    tick();
    checks++;
    if (bus.state_o !== LOAD_A || bus.D_Addr !== 8'd5 || bus.RF_s !== 1'b1 ||
        bus.RF_W_addr !== 4'd1 || bus.RF_W_en !== 1'b0 || bus.D_wr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_a state=%0d daddr=%0d rfs=%b waddr=%0d wen=%b dwr=%b exp 3/5/1/1/0/0",
               bus.state_o, bus.D_Addr, bus.RF_s, bus.RF_W_addr, bus.RF_W_en, bus.D_wr);
    end
    tick();
    checks++;
    if (bus.state_o !== LOAD_B || bus.D_Addr !== 8'd5 || bus.RF_s !== 1'b1 ||
        bus.RF_W_addr !== 4'd1 || bus.RF_W_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_b state=%0d daddr=%0d rfs=%b waddr=%0d wen=%b exp 4/5/1/1/1",
               bus.state_o, bus.D_Addr, bus.RF_s, bus.RF_W_addr, bus.RF_W_en);
    end
    tick();
    checks++;
    if (bus.state_o !== FETCH || bus.IM_addr !== 7'd1 || bus.RF_W_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_next_fetch state=%0d addr=%0d wen=%b exp 1/1/0",
               bus.state_o, bus.IM_addr, bus.RF_W_en);
    end
    checks++;
    if (regs[1] !== 16'd3) begin
      failures++;
      $display("[TB] FAIL load_writeback got=%0d exp=3", regs[1]);
    end
  endtask

  task automatic test_alu();
    logic [15:0] instr [0:1];
    logic [3:0]  exp_sel [0:1];
    instr[0] = 16'h3123; exp_sel[0] = 4'd1;
    instr[1] = 16'h4123; exp_sel[1] = 4'd2;
    for (int k = 0; k < 2; k++) begin
      clear_rom();
      rom[0] = instr[k];
      do_reset();
      tick();
      tick();
      tick();
      checks++;
      if (bus.RF_Ra_addr !== 4'd1 || bus.RF_Rb_addr !== 4'd2 || bus.RF_W_addr !== 4'd3 ||
          bus.Alu_s0 !== exp_sel[k] || bus.RF_s !== 1'b0 || bus.RF_W_en !== 1'b1 || bus.D_wr !== 1'b0) begin
        failures++;
        $display("[TB] FAIL alu_exec instr=%h ra=%0d rb=%0d wa=%0d sel=%0d rfs=%b wen=%b dwr=%b exp 1/2/3/%0d/0/1/0",
                 instr[k], bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr, bus.Alu_s0,
                 bus.RF_s, bus.RF_W_en, bus.D_wr, exp_sel[k]);
      end
      tick();
      checks++;
      if (bus.state_o !== FETCH || bus.RF_W_en !== 1'b0 || bus.Alu_s0 !== 4'd0 || bus.IM_addr !== 7'd1) begin
        failures++;
        $display("[TB] FAIL alu_after instr=%h state=%0d wen=%b sel=%0d addr=%0d exp 1/0/0/1",
                 instr[k], bus.state_o, bus.RF_W_en, bus.Alu_s0, bus.IM_addr);
      end
    end
  endtask

  task automatic test_program();
    int halt_cycle;
    int store_seen;
    clear_rom();
    rom[0] = 16'h2051;
    rom[1] = 16'h2062;
    rom[2] = 16'h3123;
    rom[3] = 16'h1073;
    rom[4] = 16'h5000;
    do_reset();
    halt_cycle = -1;
    store_seen = 0;
    for (int cyc = 1; cyc <= 40 && halt_cycle < 0; cyc++) begin
      tick();
      if (bus.halted === 1'b1) halt_cycle = cyc;
      if (bus.D_wr === 1'b1) begin
        store_seen++;
        checks++;
        if (bus.D_Addr !== 8'd7 || bus.RF_Ra_addr !== 4'd3 || bus.RF_W_en !== 1'b0) begin
          failures++;
          $display("[TB] FAIL prog_store daddr=%0d ra=%0d wen=%b exp 7/3/0",
                   bus.D_Addr, bus.RF_Ra_addr, bus.RF_W_en);
        end
      end
    end
    checks++;
    if (halt_cycle != 17) begin
      failures++;
      $display("[TB] FAIL prog_halt_cycle got=%0d exp=17", halt_cycle);
    end
    checks++;
    if (store_seen != 1) begin
      failures++;
      $display("[TB] FAIL prog_store_count got=%0d exp=1", store_seen);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (bus.halted !== 1'b1 || bus.IM_rd !== 1'b0 || bus.state_o !== HALT) begin
        failures++;
        $display("[TB] FAIL prog_halt_hold cycle=%0d halted=%b rd=%b state=%0d exp 1/0/8",
                 c, bus.halted, bus.IM_rd, bus.state_o);
      end
    end
    checks++;
    if (dmem[7] !== 16'd7) begin
      failures++;
      $display("[TB] FAIL prog_dmem7 got=%0d exp=7", dmem[7]);
    end
  endtask

  task automatic test_noop_wrap();
    clear_rom();
    rom[5] = 16'hA000;
    do_reset();
    tick();
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (bus.state_o !== FETCH || bus.IM_addr !== 7'(i)) begin
        failures++;
        $display("[TB] FAIL noop_fetch i=%0d state=%0d addr=%0d exp state=1 addr=%0d",
                 i, bus.state_o, bus.IM_addr, i);
      end
      tick();
      checks++;
      if (bus.state_o !== DECODE || bus.D_wr !== 1'b0 || bus.RF_W_en !== 1'b0) begin
        failures++;
        $display("[TB] FAIL noop_decode i=%0d state=%0d dwr=%b wen=%b exp 2/0/0",
                 i, bus.state_o, bus.D_wr, bus.RF_W_en);
      end
      tick();
    end
    checks++;
    if (bus.state_o !== FETCH || bus.IM_addr !== 7'd0) begin
      failures++;
      $display("[TB] FAIL pc_wrap state=%0d addr=%0d exp state=1 addr=0", bus.state_o, bus.IM_addr);
    end
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[0] = 16'h2051;
    do_reset();
    tick();
    tick();
    tick();
    checks++;
    if (bus.state_o !== LOAD_A) begin
      failures++;
      $display("[TB] FAIL mid_reach_load_a got=%0d exp=3", bus.state_o);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (all_out !== 40'h0) begin
      failures++;
      $display("[TB] FAIL mid_async_zero got=%h exp=0", all_out);
    end
    tick();
    checks++;
    if (bus.RF_W_en !== 1'b0 || regs[1] !== 16'd0) begin
      failures++;
      $display("[TB] FAIL mid_no_write wen=%b r1=%0d exp 0/0", bus.RF_W_en, regs[1]);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.state_o !== FETCH || bus.IM_addr !== 7'd0) begin
      failures++;
      $display("[TB] FAIL mid_restart state=%0d addr=%0d exp 1/0", bus.state_o, bus.IM_addr);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    model_init = 1'b1;
    test_reset();
    test_load();
    test_alu();
    test_program();
    test_noop_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
